instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- IF stage of the 5-stage LEGv8 pipeline. It owns the PC and the IF/ID pipeline register, and is the producer side of the ID-stage interface (instruction_ID, pc_ID).
- Fetches from instruction memory over a req/ack handshake with variable latency.
- Honours pc_stall from the hazard unit and redirects on a taken branch or unconditional branch.
- Inserts bubbles on flush or on an empty fetch.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- BUBBLE_INSTR, 32'h0, instruction_ID value driven with valid_ID=0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pc_stall  in  1  hold PC and IF/ID register (load-use hazard).
- redirect  in  1  taken branch / unconditional branch resolved downstream; flush IF/ID.
- branch_target  in  64  new PC when redirect=1.
- imem_req  out  1  fetch request valid.
- imem_addr  out  64  fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  response valid this cycle; may arrive in the same cycle as req.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- instruction_ID  out  32  IF/ID instruction.
- pc_ID  out  64  IF/ID PC of instruction_ID.
- valid_ID  out  1  IF/ID holds a real instruction.
- fetch_count  out  32  delivered-instruction counter (optional feature).
- stall_cycles  out  32  cycles with pc_stall=1 (optional feature).

Behaviour:
- Reset (sync, reset=1 at posedge):
  - pc=RESET_PC, state=REQ.
  - instruction_ID=BUBBLE_INSTR, pc_ID=0, valid_ID=0, holding buffer cleared.
  - imem_req=0 in any cycle where reset=1.
  - Reset mid-request abandons the request. Memory must tolerate a dropped req.
- States:
  - REQ: imem_req=1, imem_addr=pc.
    - ack and !pc_stall: IF/ID <= {imem_rdata, pc, valid=1}; pc <= pc+4; stay REQ. This gives one instruction per cycle with zero-latency memory.
    - ack and pc_stall: capture {rdata, pc} into holding buffer; IF/ID unchanged; pc <= pc+4; go HOLD.
    - no ack and !pc_stall: IF/ID <= bubble (valid_ID=0, instruction_ID=BUBBLE_INSTR, pc_ID unchanged).
    - no ack and pc_stall: IF/ID unchanged.
  - HOLD: imem_req=0.
    - When !pc_stall: IF/ID <= holding buffer, valid=1; go REQ.
  - DRAIN: imem_req=1 with the old imem_addr until ack. The rdata is discarded, then go REQ at the redirected pc. IF/ID stays bubble.
- Redirect has top priority after reset and overrides pc_stall:
  - pc <= {branch_target[63:2], 2'b00}.
  - IF/ID <= bubble.
  - Holding buffer discarded.
  - Next state:
    - from REQ with ack: REQ.
    - from REQ without ack: DRAIN.
    - from HOLD: REQ.
    - from DRAIN: stay DRAIN, and the later target wins.
- Latency: first fetch is presented on imem_addr in the cycle after reset deasserts. With an ack in that cycle, valid_ID=1 at the next posedge.
- Arithmetic: pc+4 wraps modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC -> 0.
- Ordering: valid instructions appear on IF/ID in strict PC order. None are dropped or duplicated except those flushed by redirect.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - fetch_count increments on every IF/ID load with valid=1.
  - stall_cycles increments every cycle with pc_stall=1 and reset=0.
  - Both counters are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset then zero-latency memory returning rdata=32'hF84003E9 at addr 0 and 32'hAA1F012A at addr 4 -> valid_ID=1 with pc_ID=0/instruction_ID=F84003E9, then pc_ID=4/instruction_ID=AA1F012A, on consecutive cycles.
- ack delayed 3 cycles for addr 8 -> imem_addr held at 8 for 3 cycles; valid_ID=0 for those cycles; then pc_ID=8.
- pc_stall=1 for 2 cycles while ack arrives for addr 12 -> IF/ID holds previous instruction; imem_req=0 in HOLD; after release, pc_ID=12 then addr 16 fetched.
- redirect=1, branch_target=64'h40 while addr 20 outstanding, ack 2 cycles later -> DRAIN; addr-20 data never reaches IF/ID; next imem_addr=64'h40; valid_ID=0 until addr 40 delivered.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> fetches FFFF..FFFC, then addr 0; reset asserted mid-wait -> imem_req=0 and valid_ID=0 next cycle.
- FETCH_PERF_EN defined: 5 delivered instructions and 3 stall cycles -> fetch_count=5, stall_cycles=3; undefined -> both 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage of the 5-stage LEGv8 pipeline.
// Owns the PC and the IF/ID register, fetches over a req/ack instruction
// memory port with variable latency, holds on pc_stall, flushes on redirect.
// Optional feature macro: FETCH_PERF_EN (fetch_count / stall_cycles counters).
module instruction_fetch #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_stall,
    input  logic        redirect,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_ID,
    output logic [63:0] pc_ID,
    output logic        valid_ID,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic [63:0] r_drain_addr;
    logic [31:0] r_hold_instr;
    logic [63:0] r_hold_pc;
    logic [31:0] r_instr;
    logic [63:0] r_pc_id;
    logic        r_valid;

    logic [1:0]  w_state_nxt;
    logic [63:0] w_pc_nxt;
    logic [63:0] w_drain_nxt;
    logic [31:0] w_hold_instr_nxt;
    logic [63:0] w_hold_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [63:0] w_pc_id_nxt;
    logic        w_valid_nxt;
    logic [63:0] w_target;

    // Branch targets are forced to word alignment.
    assign w_target = branch_target & 64'hFFFF_FFFF_FFFF_FFFC;

    // Reset kills the request in the same cycle so a pending fetch is abandoned.
    assign imem_req  = !reset && ((r_state == S_REQ) || (r_state == S_DRAIN));
    // DRAIN keeps the flushed address on the bus until its ack arrives.
    assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;

    assign instruction_ID = r_instr;
    assign pc_ID          = r_pc_id;
    assign valid_ID       = r_valid;

    // Next-state logic: redirect first, then the per-state fetch/stall rules.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drain_nxt      = r_drain_addr;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;
        w_instr_nxt      = r_instr;
        w_pc_id_nxt      = r_pc_id;
        w_valid_nxt      = r_valid;
        if (redirect) begin
            w_pc_nxt         = w_target;
            w_instr_nxt      = BUBBLE_INSTR;
            w_valid_nxt      = 1'b0;
            w_hold_instr_nxt = 32'h0;
            w_hold_pc_nxt    = 64'h0;
            case (r_state)
                S_REQ: begin
                    if (imem_ack) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        // The outstanding request must still complete; discard it.
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = r_pc;
                    end
                end
                S_HOLD:  w_state_nxt = S_REQ;
                S_DRAIN: w_state_nxt = S_DRAIN;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_ack) begin
                        w_pc_nxt = r_pc + 64'd4;
                        if (pc_stall) begin
                            w_hold_instr_nxt = imem_rdata;
                            w_hold_pc_nxt    = r_pc;
                            w_state_nxt      = S_HOLD;
                        end else begin
                            w_instr_nxt = imem_rdata;
                            w_pc_id_nxt = r_pc;
                            w_valid_nxt = 1'b1;
                        end
                    end else if (!pc_stall) begin
                        w_instr_nxt = BUBBLE_INSTR;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_valid_nxt = r_valid;
                    end
                end
                S_HOLD: begin
                    if (!pc_stall) begin
                        w_instr_nxt = r_hold_instr;
                        w_pc_id_nxt = r_hold_pc;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    // PC, FSM, holding buffer and IF/ID register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_drain_addr <= 64'h0;
            r_hold_instr <= 32'h0;
            r_hold_pc    <= 64'h0;
            r_instr      <= BUBBLE_INSTR;
            r_pc_id      <= 64'h0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_pc_id      <= w_pc_id_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_cycles;
    logic        w_load_valid;

    // A valid IF/ID load happens on a direct fetch or on release of HOLD.
    assign w_load_valid = !redirect && !pc_stall &&
                          (((r_state == S_REQ) && imem_ack) || (r_state == S_HOLD));

    // Performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count  <= 32'd0;
            r_stall_cycles <= 32'd0;
        end else begin
            if (w_load_valid) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (pc_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign fetch_count  = r_fetch_count;
    assign stall_cycles = r_stall_cycles;
`else
    assign fetch_count  = 32'd0;
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a transaction-level model predicts
// which fetched words reach IF/ID; a negedge monitor pops and compares.
module tb_instruction_fetch;

    localparam logic [63:0] RST_PC = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [31:0] BUB    = 32'hD503_201F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] branch_target = 64'h0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction_ID;
    logic [63:0] pc_ID;
    logic        valid_ID;
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(RST_PC), .BUBBLE_INSTR(BUB)) dut (
        .clk(clk), .reset(reset), .pc_stall(pc_stall), .redirect(redirect),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction_ID(instruction_ID),
        .pc_ID(pc_ID), .valid_ID(valid_ID), .fetch_count(fetch_count),
        .stall_cycles(stall_cycles)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'hF840_03E9;
        if (a == 64'h4) return 32'hAA1F_012A;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } item_t;

    // Reference model: next useful fetch address, a flushed request still in
    // flight, a fetched word blocked by stall, and the expected IF/ID stream.
    item_t       exp_q[$];
    logic [63:0] m_pc;
    bit          m_flushed_out;
    logic [63:0] m_flush_addr;
    bit          m_waiting;
    logic [31:0] m_fc, m_sc;
    bit          exp_req;
    logic [63:0] exp_addr;
    bit          edge_reset, edge_stall, edge_redirect;
    bit          started = 1'b0;
    logic [31:0] prev_instr;
    logic [63:0] prev_pc;
    logic        prev_valid;

    // Advance the model by one clock edge, using the inputs held at that edge.
    task automatic model_edge();
        edge_reset    = reset;
        edge_stall    = pc_stall;
        edge_redirect = redirect;
        if (reset) begin
            if (started) chk("queue_at_reset", exp_q.size() - int'(m_waiting), 0);
            exp_q.delete();
            m_pc = RST_PC; m_flushed_out = 1'b0; m_waiting = 1'b0;
            m_fc = 32'd0; m_sc = 32'd0;
        end else begin
            if (pc_stall) m_sc = m_sc + 32'd1;
            if (redirect) begin
                if (m_waiting) begin
                    void'(exp_q.pop_back());
                    m_waiting = 1'b0;
                end else if (!m_flushed_out && !imem_ack) begin
                    m_flushed_out = 1'b1;
                    m_flush_addr  = m_pc;
                end
                m_pc = branch_target & 64'hFFFF_FFFF_FFFF_FFFC;
            end else if (m_flushed_out) begin
                if (imem_ack) m_flushed_out = 1'b0;
            end else if (m_waiting) begin
                if (!pc_stall) begin
                    m_waiting = 1'b0;
                    m_fc = m_fc + 32'd1;
                end
            end else if (imem_ack) begin
                exp_q.push_back('{pc: m_pc, ins: mem_word(m_pc)});
                m_pc = m_pc + 64'd4;
                if (pc_stall) m_waiting = 1'b1;
                else m_fc = m_fc + 32'd1;
            end
        end
    endtask

    // One cycle of stimulus: settle the model on the edge, then apply inputs.
    task automatic step(input bit r, input bit st, input bit rd,
                        input logic [63:0] tgt, input bit ak);
        @(posedge clk);
        #1;
        model_edge();
        started       = 1'b1;
        reset         = r;
        pc_stall      = st;
        redirect      = rd;
        branch_target = tgt;
        exp_req       = !r && !m_waiting;
        exp_addr      = m_flushed_out ? m_flush_addr : m_pc;
        imem_ack      = exp_req && ak;
        imem_rdata    = imem_ack ? mem_word(imem_addr) : $urandom();
    endtask

    // Monitor: checks the fetch port and pops the scoreboard on IF/ID loads.
    always @(negedge clk) begin
        if (started) begin
            chk("imem_req", imem_req, exp_req);
            if (exp_req) chk("imem_addr", imem_addr, exp_addr);
            if (edge_reset) begin
                chk("rst_valid", valid_ID, 0);
                chk("rst_pc_ID", pc_ID, 0);
                chk("rst_instr", instruction_ID, BUB);
            end else if (edge_redirect) begin
                chk("flush_valid", valid_ID, 0);
                chk("flush_instr", instruction_ID, BUB);
            end else if (edge_stall) begin
                chk("stall_valid", valid_ID, prev_valid);
                chk("stall_pc_ID", pc_ID, prev_pc);
                chk("stall_instr", instruction_ID, prev_instr);
            end else if (valid_ID) begin
                chk("expected_present", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    item_t it;
                    it = exp_q.pop_front();
                    chk("pc_ID", pc_ID, it.pc);
                    chk("instruction_ID", instruction_ID, it.ins);
                end
            end else begin
                chk("bubble_instr", instruction_ID, BUB);
            end
`ifdef FETCH_PERF_EN
            chk("fetch_count", fetch_count, m_fc);
            chk("stall_cycles", stall_cycles, m_sc);
`else
            chk("fetch_count_tied", fetch_count, 0);
            chk("stall_cycles_tied", stall_cycles, 0);
`endif
            prev_valid = valid_ID;
            prev_pc    = pc_ID;
            prev_instr = instruction_ID;
        end
    end

    // Directed prologue, fields {reset, stall, redirect, ack}: wrap past the
    // top of memory, delayed ack, stall during ack, redirect while waiting,
    // and reset while a request is outstanding.
    logic [3:0] dir_tab [0:31] = '{
        4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
        4'b0000, 4'b0001, 4'b0101, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0010,
        4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0001,
        4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0001, 4'b0110, 4'b0001
    };

    initial begin
        for (int i = 0; i < 32; i++) begin
            logic [3:0] v;
            v = dir_tab[i];
            step(v[3], v[2], v[1], 64'h40 | 64'(i[1:0]), v[0]);
        end
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] tgt;
            case ($urandom_range(0, 2))
                0:       tgt = {32'h0, 32'($urandom_range(0, 255))};
                1:       tgt = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
                default: tgt = {$urandom(), $urandom()};
            endcase
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 8, tgt, $urandom_range(0, 99) < 55);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
